// File: rtl/abs_arb_pkg.sv
// Shared constants and helpers for the shared absolute-value arbiter.
package abs_arb_pkg;

  localparam int unsigned W_DEFAULT = 32;
  // Largest requester count the round-robin picker supports.
  localparam int unsigned N_MAX     = 16;

  // Most negative two's-complement value of width w, zero-extended to 64 bits.
  function automatic logic [63:0] min_neg(int unsigned w);
    return 64'(1) << (w - 1);
  endfunction

  // One-hot pick of the first set request at or after ptr, wrapping modulo n.
  function automatic logic [N_MAX-1:0] rr_pick(logic [N_MAX-1:0] req, int unsigned ptr,
                                               int unsigned n);
    logic [N_MAX-1:0] pick;
    int unsigned      idx;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_MAX; i++) begin
      idx = (ptr + i) % n;
      if (i < n && !found && req[idx[3:0]]) begin
        pick[idx[3:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/abs_core.sv
// Combinational two's-complement absolute value with MIN_NEG flag and optional saturation.
module abs_core
  import abs_arb_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] operand,
  input  logic         cfg_sat,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam logic [W-1:0] MinNeg = W'(min_neg(W));

  // MIN_NEG has no positive counterpart: flag it and either wrap or clamp.
  always_comb begin
    ovf = (operand == MinNeg);
    if (ovf) begin
      result = cfg_sat ? ~MinNeg : MinNeg;
    end else if (operand[W-1]) begin
      result = ~operand + W'(1);
    end else begin
      result = operand;
    end
  end

endmodule

// File: rtl/abs_share_arbiter.sv
// Round-robin arbiter sharing one abs_core among N requesters, with a registered result slot.
module abs_share_arbiter
  import abs_arb_pkg::*;
#(
  parameter  int unsigned N   = 4,
  parameter  int unsigned W   = W_DEFAULT,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_data,
  input  logic           cfg_sat,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_ovf
);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           rsp_valid_q;
  logic [W-1:0]   rsp_data_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_ovf_q;

  logic           slot_free;
  logic [N_MAX-1:0] pick;
  logic [N-1:0]   grant;
  logic [IDW-1:0] gnt_idx;
  logic [W-1:0]   operand;
  logic [W-1:0]   abs_result;
  logic           abs_ovf;

  // Slot accepts a new operand when empty or being drained this cycle.
  assign slot_free = ~rsp_valid_q | rsp_ready;

  // Grant selection; gated by rst_n so nothing is accepted while in reset.
  always_comb begin
    pick  = rr_pick(N_MAX'(req_valid), 32'(rr_ptr_q), N);
    grant = (slot_free && rst_n) ? pick[N-1:0] : '0;
  end

  assign req_ready = grant;

  // Encode the grant and mux the winning operand into the shared datapath.
  always_comb begin
    gnt_idx = '0;
    operand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        gnt_idx = IDW'(i);
        operand = req_data[i*W +: W];
      end
    end
  end

  abs_core #(
    .W(W)
  ) u_abs_core (
    .operand(operand),
    .cfg_sat(cfg_sat),
    .result (abs_result),
    .ovf    (abs_ovf)
  );

  // Pointer advances past the winner only on an actual transfer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant) begin
      rr_ptr_d = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output slot: load on transfer, clear on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
    end else if (|grant) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= abs_result;
      rsp_id_q    <= gnt_idx;
      rsp_ovf_q   <= abs_ovf;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_abs_share_arbiter.sv
// Randomized self-checking bench for abs_share_arbiter against a transaction-level model.
module tb_abs_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic           cfg_sat;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ovf;

  int errors = 0;
  int checks = 0;

  // Model state: pending result slot and round-robin pointer.
  logic        exp_valid;
  logic [31:0] exp_data;
  logic [1:0]  exp_id;
  logic        exp_ovf;
  int          ptr;
  int          exp_gnt;
  logic [3:0]  exp_ready;

  abs_share_arbiter #(
    .N(N),
    .W(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .cfg_sat  (cfg_sat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .rsp_ovf  (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] ref_abs(logic [31:0] x, logic sat);
    if (x == 32'h8000_0000) return {1'b1, (sat ? 32'h7FFF_FFFF : 32'h8000_0000)};
    if ($signed(x) < 0) return {1'b0, 32'(-$signed(x))};
    return {1'b0, x};
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_id    = '0;
    exp_ovf   = 1'b0;
    ptr       = 0;
  endtask

  // Settle inputs, then predict which requester wins this cycle.
  task automatic predict();
    #1;
    exp_gnt = -1;
    if (rst_n && (!exp_valid || rsp_ready)) begin
      for (int k = 0; k < N; k++) begin
        if (exp_gnt < 0 && req_valid[(ptr + k) % N]) exp_gnt = (ptr + k) % N;
      end
    end
    exp_ready = (exp_gnt >= 0) ? 4'(1 << exp_gnt) : 4'b0;
  endtask

  // Clock edge, model update, then move to the falling edge for the next drive.
  task automatic advance();
    logic [32:0] r;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (exp_gnt >= 0) begin
      r         = ref_abs(req_data[exp_gnt*W +: W], cfg_sat);
      exp_valid = 1'b1;
      exp_data  = r[31:0];
      exp_ovf   = r[32];
      exp_id    = 2'(exp_gnt);
      ptr       = (exp_gnt + 1) % N;
    end else if (rsp_ready) begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = {32'd4, 32'd3, 32'd2, 32'd1};
    cfg_sat   = 1'b0;
    rsp_ready = 1'b1;
    model_reset();
    @(negedge clk);
    predict();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h id=%0d ovf=%b want 0/0/0/0",
               rsp_valid, rsp_data, rsp_id, rsp_ovf);
    end
    checks++;
    if (req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    rst_n = 1'b1;
    predict();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    req_valid = 4'b0;
    predict();
    advance();
  endtask

  task automatic test_values();
    logic [31:0] vals [4] = '{32'h0, 32'h5, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] want [4] = '{32'h0, 32'h5, 32'h1, 32'h7FFF_FFFF};
    rsp_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      req_valid = (i < 4) ? 4'b0001 : 4'b0000;
      if (i < 4) req_data[31:0] = vals[i];
      predict();
      if (i > 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== want[i-1] || rsp_ovf !== 1'b0 || rsp_id !== 2'd0)
        begin
          errors++;
          $display("FAIL value_%0d: got v=%b d=%h id=%0d ovf=%b want 1/%h/0/0",
                   i - 1, rsp_valid, rsp_data, rsp_id, rsp_ovf, want[i-1]);
        end
      end
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL value_ready_%0d: got %b want %b", i, req_ready, exp_ready);
      end
      advance();
    end
  endtask

  task automatic test_min_neg();
    logic [31:0] want [2] = '{32'h8000_0000, 32'h7FFF_FFFF};
    rsp_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cfg_sat        = s[0];
      req_valid      = 4'b0001;
      req_data[31:0] = 32'h8000_0000;
      predict();
      advance();
      // Transfer done; flip cfg_sat and stall to show it is not re-sampled.
      req_valid = 4'b0;
      cfg_sat   = ~cfg_sat;
      rsp_ready = 1'b0;
      predict();
      advance();
      predict();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== want[s] || rsp_ovf !== 1'b1) begin
        errors++;
        $display("FAIL min_neg_sat%0d: got v=%b d=%h ovf=%b want 1/%h/1",
                 s, rsp_valid, rsp_data, rsp_ovf, want[s]);
      end
      rsp_ready = 1'b1;
      predict();
      advance();
    end
    cfg_sat = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held_data;
    logic [1:0]  held_id;
    logic        held_ovf;
    req_valid = 4'hF;
    req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    rsp_ready = 1'b1;
    predict();
    advance();
    rsp_ready = 1'b0;
    held_data = rsp_data;
    held_id   = rsp_id;
    held_ovf  = rsp_ovf;
    for (int c = 0; c < 5; c++) begin
      predict();
      checks++;
      if (req_ready !== 4'b0 || rsp_valid !== 1'b1 || rsp_data !== exp_data ||
          rsp_id !== exp_id || rsp_ovf !== exp_ovf || rsp_data !== held_data ||
          rsp_id !== held_id || rsp_ovf !== held_ovf) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got rdy=%b v=%b d=%h id=%0d ovf=%b want 0000/1/%h/%0d/%b",
                 c, req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf, exp_data, exp_id, exp_ovf);
      end
      advance();
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      predict();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== exp_id ||
          req_ready !== exp_ready) begin
        errors++;
        $display("FAIL backpressure_drain_%0d: got v=%b d=%h id=%0d rdy=%b want 1/%h/%0d/%b",
                 c, rsp_valid, rsp_data, rsp_id, req_ready, exp_data, exp_id, exp_ready);
      end
      advance();
    end
  endtask

  task automatic test_reset_midstream();
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    predict();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_precondition: got rsp_valid=%b want 1", rsp_valid);
    end
    rst_n = 1'b0;
    predict();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL midreset_drop: got v=%b rdy=%b want 0/0000", rsp_valid, req_ready);
    end
    advance();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    predict();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_first_grant: got %b want 0001", req_ready);
    end
    req_valid = 4'b0;
    predict();
    advance();
  endtask

  task automatic test_fairness();
    int got = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 12) ? 4'hF : 4'h0;
      req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      predict();
      if (c > 0) begin
        got++;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % N) || rsp_data !== exp_data) begin
          errors++;
          $display("FAIL fairness_%0d: got v=%b id=%0d d=%h want 1/%0d/%h",
                   c - 1, rsp_valid, rsp_id, rsp_data, (c - 1) % N, exp_data);
        end
      end
      advance();
    end
    predict();
    checks++;
    if (got != 12 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fairness_count: got %0d results then v=%b want 12 then 0", got, rsp_valid);
    end
  endtask

  task automatic test_sparse();
    rsp_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      req_valid = 4'b0100;
      predict();
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL sparse_req2_%0d: got %b want 0100", r, req_ready);
      end
      advance();
    end
    req_valid = 4'b1010;
    predict();
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL sparse_req3_first: got %b want 1000", req_ready);
    end
    advance();
    predict();
    checks++;
    if (req_ready !== 4'b0010 || rsp_id !== 2'd3) begin
      errors++;
      $display("FAIL sparse_req1_next: got rdy=%b id=%0d want 0010/3", req_ready, rsp_id);
    end
    advance();
    req_valid = 4'b0;
    predict();
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom());
      for (int i = 0; i < N; i++) req_data[i*W +: W] = rand_operand();
      cfg_sat   = 1'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      predict();
      checks++;
      if (rsp_valid !== exp_valid || req_ready !== exp_ready ||
          (exp_valid && (rsp_data !== exp_data || rsp_id !== exp_id || rsp_ovf !== exp_ovf)))
      begin
        errors++;
        $display("FAIL random_%0d: got v=%b d=%h id=%0d ovf=%b rdy=%b want %b/%h/%0d/%b/%b",
                 c, rsp_valid, rsp_data, rsp_id, rsp_ovf, req_ready,
                 exp_valid, exp_data, exp_id, exp_ovf, exp_ready);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_min_neg();
    test_backpressure();
    test_reset_midstream();
    test_fairness();
    test_sparse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
